// File: rtl/dm_store_align.sv
// M-stage data memory: store byte-lane alignment, address exception detection,
// synchronous word read registered across the M/W boundary.
module dm_store_align #(
    parameter int DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  StoreOp,
    input  logic [2:0]  LoadOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic        ExcFlush,
    output logic [3:0]  ByteEn,
    output logic        AdEL,
    output logic        AdES,
    output logic [31:0] DM_RData_W,
    output logic [31:0] RData2_W,
    output logic [1:0]  Addr2_W,
    output logic [2:0]  DEXTOp_W
);

    localparam int          IDX_W      = $clog2(DM_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS * 4);

    localparam logic [2:0] ST_NONE = 3'b000;
    localparam logic [2:0] ST_SW   = 3'b001;
    localparam logic [2:0] ST_SH   = 3'b010;
    localparam logic [2:0] ST_SB   = 3'b011;
    localparam logic [2:0] ST_SWL  = 3'b100;
    localparam logic [2:0] ST_SWR  = 3'b101;

    localparam logic [2:0] LD_LW   = 3'b000;
    localparam logic [2:0] LD_LH   = 3'b001;
    localparam logic [2:0] LD_LHU  = 3'b010;

    logic [31:0]      mem [DM_WORDS];
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic [3:0]       be_raw;
    logic [31:0]      wlane;
    logic             write_ok;

    assign off          = Addr[1:0];
    assign idx          = Addr[IDX_W+1:2];
    assign out_of_range = (Addr >= ADDR_LIMIT);

    // Lane enables and lane-shifted data before any exception/flush gating.
    always_comb begin
        be_raw = 4'b0000;
        wlane  = 32'h0;
        case (StoreOp)
            ST_SW: begin
                be_raw = 4'b1111;
                wlane  = WData;
            end
            ST_SH: begin
                be_raw = off[1] ? 4'b1100 : 4'b0011;
                wlane  = {2{WData[15:0]}};
            end
            ST_SB: begin
                be_raw = 4'b0001 << off;
                wlane  = {4{WData[7:0]}};
            end
            ST_SWL: begin
                // Most-significant rt bytes fill the word from byte 0 up to off.
                case (off)
                    2'd0:    be_raw = 4'b0001;
                    2'd1:    be_raw = 4'b0011;
                    2'd2:    be_raw = 4'b0111;
                    default: be_raw = 4'b1111;
                endcase
                wlane = WData >> {3'(2'd3 - off), 3'b000};
            end
            ST_SWR: begin
                be_raw = 4'b1111 << off;
                wlane  = WData << {off, 3'b000};
            end
            default: begin
                be_raw = 4'b0000;
                wlane  = 32'h0;
            end
        endcase
    end

    assign AdES = MemWrite && (StoreOp != ST_NONE) &&
                  (out_of_range ||
                   ((StoreOp == ST_SW) && (off != 2'd0)) ||
                   ((StoreOp == ST_SH) && off[0]));

    assign AdEL = MemRead &&
                  (out_of_range ||
                   ((LoadOp == LD_LW) && (off != 2'd0)) ||
                   (((LoadOp == LD_LH) || (LoadOp == LD_LHU)) && off[0]));

    // Reset also blanks the lanes so nothing appears enabled while it is held.
    assign write_ok = MemWrite && (StoreOp != ST_NONE) && !AdES && !ExcFlush && !reset;
    assign ByteEn   = write_ok ? be_raw : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ByteEn[k]) begin
                    mem[idx][8*k +: 8] <= wlane[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DM_RData_W <= 32'h0;
            RData2_W   <= 32'h0;
            Addr2_W    <= 2'b00;
            DEXTOp_W   <= 3'b000;
        end else begin
            // Non-blocking read returns the word as it was before this edge's write.
            if (MemRead && !AdEL) begin
                DM_RData_W <= mem[idx];
            end else begin
                DM_RData_W <= 32'h0;
            end
            RData2_W <= WData;
            Addr2_W  <= Addr[1:0];
            DEXTOp_W <= MemRead ? LoadOp : 3'b000;
        end
    end

endmodule

// File: tb/tb_dm_store_align.sv
// Randomized + directed bench for dm_store_align against a byte-addressed
// reference memory that applies store rules byte by byte.
module tb_dm_store_align;

    localparam int DM_WORDS = 3072;
    localparam int NBYTES   = DM_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  StoreOp;
    logic [2:0]  LoadOp;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        ExcFlush;
    logic [3:0]  ByteEn;
    logic        AdEL;
    logic        AdES;
    logic [31:0] DM_RData_W;
    logic [31:0] RData2_W;
    logic [1:0]  Addr2_W;
    logic [2:0]  DEXTOp_W;

    logic [7:0] ref_mem [NBYTES];
    int n_tests = 0;
    int n_fail  = 0;

    dm_store_align #(.DM_WORDS(DM_WORDS)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .StoreOp(StoreOp), .LoadOp(LoadOp), .Addr(Addr), .WData(WData),
        .ExcFlush(ExcFlush), .ByteEn(ByteEn), .AdEL(AdEL), .AdES(AdES),
        .DM_RData_W(DM_RData_W), .RData2_W(RData2_W), .Addr2_W(Addr2_W),
        .DEXTOp_W(DEXTOp_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'({a[31:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, check registers, update model.
    task automatic step(input logic mw, input logic mr, input logic [2:0] sop,
                        input logic [2:0] lop, input logic [31:0] a,
                        input logic [31:0] wd, input logic fl, input logic rst);
        int          wr_addr[$];
        logic [7:0]  wr_val[$];
        int          off;
        logic        oor, exp_ades, exp_adel, allowed;
        logic [3:0]  exp_be;
        logic [31:0] exp_rd;

        MemWrite = mw; MemRead = mr; StoreOp = sop; LoadOp = lop;
        Addr = a; WData = wd; ExcFlush = fl; reset = rst;
        #1;
        oor      = (a >= 32'(NBYTES));
        off      = int'(a % 4);
        exp_ades = mw && (sop != 0) && (oor || (sop == 1 && off != 0) || (sop == 2 && (off % 2) != 0));
        exp_adel = mr && (oor || (lop == 0 && off != 0) || ((lop == 1 || lop == 2) && (off % 2) != 0));
        allowed  = mw && (sop != 0) && !exp_ades && !fl && !rst;
        if (allowed) begin
            case (sop)
                3'd1: for (int i = 0; i < 4; i++) begin wr_addr.push_back(int'(a) + i); wr_val.push_back(8'(wd >> (8*i))); end
                3'd2: for (int i = 0; i < 2; i++) begin wr_addr.push_back(int'(a) + i); wr_val.push_back(8'(wd >> (8*i))); end
                3'd3: begin wr_addr.push_back(int'(a)); wr_val.push_back(wd[7:0]); end
                3'd4: for (int i = 0; i <= off; i++) begin wr_addr.push_back(int'(a) - i); wr_val.push_back(8'(wd >> (24 - 8*i))); end
                3'd5: for (int i = 0; i <= 3 - off; i++) begin wr_addr.push_back(int'(a) + i); wr_val.push_back(8'(wd >> (8*i))); end
                default: ;
            endcase
        end
        exp_be = 4'b0000;
        foreach (wr_addr[j]) exp_be[wr_addr[j] % 4] = 1'b1;
        check("ByteEn", 32'(ByteEn), 32'(exp_be));
        check("AdES", 32'(AdES), 32'(exp_ades));
        check("AdEL", 32'(AdEL), 32'(exp_adel));
        exp_rd = (mr && !exp_adel) ? ref_word(a) : 32'h0;

        @(posedge clk);
        #1;
        if (rst) begin
            check("rst_rdata", DM_RData_W, 32'h0);
            check("rst_rdata2", RData2_W, 32'h0);
            check("rst_addr2", 32'(Addr2_W), 32'h0);
            check("rst_dextop", 32'(DEXTOp_W), 32'h0);
            foreach (ref_mem[k]) ref_mem[k] = 8'h00;
        end else begin
            check("DM_RData_W", DM_RData_W, exp_rd);
            check("RData2_W", RData2_W, wd);
            check("Addr2_W", 32'(Addr2_W), 32'(a[1:0]));
            check("DEXTOp_W", 32'(DEXTOp_W), mr ? 32'(lop) : 32'h0);
            foreach (wr_addr[j]) ref_mem[wr_addr[j]] = wr_val[j];
        end
        @(negedge clk);
    endtask

    task automatic st(input logic [2:0] sop, input logic [31:0] a, input logic [31:0] wd);
        step(1'b1, 1'b0, sop, 3'd0, a, wd, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [2:0] lop, input logic [31:0] a, input logic [31:0] wd);
        step(1'b0, 1'b1, 3'd0, lop, a, wd, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        MemWrite = 0; MemRead = 0; StoreOp = 0; LoadOp = 0;
        Addr = 0; WData = 0; ExcFlush = 0; reset = 1;
        @(negedge clk);
        step(1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Directed scenarios, with hard-coded sanity checks on the model itself
        st(3'd1, 32'h10, 32'h11223344);
        ld(3'd0, 32'h10, 32'h0);
        check("plan_sw_lw", ref_word(32'h10), 32'h11223344);

        st(3'd1, 32'h20, 32'h11223344);
        st(3'd3, 32'h21, 32'h000000AB);
        ld(3'd0, 32'h20, 32'h0);
        check("plan_sb", ref_word(32'h20), 32'h1122AB44);
        st(3'd2, 32'h22, 32'h0000CCDD);
        ld(3'd0, 32'h20, 32'h0);
        check("plan_sh", ref_word(32'h20), 32'hCCDDAB44);

        st(3'd4, 32'h31, 32'hAABBCCDD);
        check("plan_swl", ref_word(32'h30), 32'h0000AABB);
        st(3'd5, 32'h32, 32'hAABBCCDD);
        check("plan_swr", ref_word(32'h30), 32'hCCDDAABB);
        ld(3'd6, 32'h32, 32'hAABBCCDD);

        st(3'd1, 32'h40, 32'h01020304);
        st(3'd1, 32'h41, 32'hDEADBEEF);
        ld(3'd0, 32'h40, 32'h0);
        ld(3'd1, 32'h43, 32'h0);
        ld(3'd3, 32'h43, 32'h0);

        st(3'd1, 32'h3000, 32'h12345678);
        st(3'd1, 32'h2FFC, 32'h87654321);
        ld(3'd0, 32'h2FFC, 32'h0);
        ld(3'd0, 32'h3000, 32'h0);

        st(3'd1, 32'h50, 32'h55555555);
        step(1'b1, 1'b0, 3'd1, 3'd0, 32'h50, 32'hAAAAAAAA, 1'b1, 1'b0);
        ld(3'd0, 32'h50, 32'h0);
        step(1'b1, 1'b1, 3'd1, 3'd0, 32'h54, 32'h13579BDF, 1'b0, 1'b0);
        ld(3'd0, 32'h54, 32'h0);
        step(1'b1, 1'b0, 3'd1, 3'd0, 32'h50, 32'hFFFFFFFF, 1'b0, 1'b1);
        ld(3'd0, 32'h50, 32'h0);
        ld(3'd0, 32'h10, 32'h0);
        check("plan_reset_clear", ref_word(32'h50), 32'h0);

        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80)      a = $urandom_range(0, 63);
            else if (r < 90) a = 32'(NBYTES - 16) + $urandom_range(0, 15);
            else if (r < 96) a = 32'(NBYTES) + $urandom_range(0, 31);
            else             a = $urandom;
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 60),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), a, $urandom,
                 ($urandom_range(0, 99) < 8), ($urandom_range(0, 199) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
